execute_stage_mc: RTL and testbench

Parametrised successor to the single-cycle EX stage of the MIPS pipeline. It forwards operands, performs a one-cycle ALU operation, and iterates MULTU/DIVU into HI/LO registers. It stalls upstream while the multi-cycle unit is busy and registers its results into the EX/MEM boundary. It sits between the ID/EX register and the MEMORY stage.

---
 rtl/exec_pkg.sv | 43 ++++
 rtl/muldiv_iter.sv | 113 +++++++++++
 rtl/execute_stage_mc.sv | 178 +++++++++++++++++
 tb/tb_execute_stage_mc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared encodings for the multi-cycle execute stage: ALU
//                opcodes, forwarding-select values and mul/div FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_pkg;

    // ALU / multi-cycle opcodes
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_LUI   = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    // Operand forwarding sources; value 3 is reserved and behaves like FWD_ID
    localparam logic [1:0] FWD_ID    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // Mul/div sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
//  Module      : muldiv_iter
//  Description : Iterative unsigned multiplier / restoring divider with the
//                architectural HI/LO registers. One bit per cycle, NBITS
//                steps, then one commit cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter
    import exec_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             op_div,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] hi,
    output logic [NBITS-1:0] lo,
    output logic [NBITS-1:0] result_lo
);

    localparam int CW = $clog2(NBITS) + 1;

    md_state_t        state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic [NBITS-1:0] divisor;
    // Multiply: {acc_hi, acc_lo} is the shifting product, multiplier in acc_lo.
    // Divide:   acc_hi is the partial remainder, acc_lo shifts dividend out
    //           and quotient bits in. Both finish with HI=acc_hi, LO=acc_lo.
    logic [NBITS-1:0] acc_hi;
    logic [NBITS-1:0] acc_lo;

    logic [NBITS:0]   mul_sum;
    logic [NBITS:0]   div_trial;
    logic [NBITS:0]   div_diff;
    logic             div_ge;
    logic [NBITS-1:0] next_hi;
    logic [NBITS-1:0] next_lo;

    // One shift-add or restoring-subtract step
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : '0);
        div_trial = {acc_hi, acc_lo[NBITS-1]};
        div_ge    = (div_trial >= {1'b0, divisor});
        div_diff  = div_trial - {1'b0, divisor};
        if (is_div) begin
            next_hi = div_ge ? div_diff[NBITS-1:0] : div_trial[NBITS-1:0];
            next_lo = {acc_lo[NBITS-2:0], div_ge};
        end else begin
            next_hi = mul_sum[NBITS:1];
            next_lo = {mul_sum[0], acc_lo[NBITS-1:1]};
        end
    end

    // Sequencer: load, iterate, commit to HI/LO, or abandon on flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MD_IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            divisor <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                MD_RUN: begin
                    if (flush) begin
                        state <= MD_IDLE;
                    end else if (count != '0) begin
                        acc_hi <= next_hi;
                        acc_lo <= next_lo;
                        count  <= count - CW'(1);
                    end else begin
                        hi    <= acc_hi;
                        lo    <= acc_lo;
                        state <= MD_DONE;
                    end
                end
                default: begin
                    // DONE behaves like IDLE so an op presented in the DONE
                    // cycle (stall already low) is not lost
                    if (start) begin
                        state   <= MD_RUN;
                        count   <= CW'(NBITS);
                        is_div  <= op_div;
                        divisor <= b;
                        acc_hi  <= '0;
                        acc_lo  <= a;
                    end else begin
                        state <= MD_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = (state == MD_RUN);
    assign done      = (state == MD_RUN) && (count == '0) && !flush;
    assign result_lo = acc_lo;

endmodule

`default_nettype wire

// File: rtl/execute_stage_mc.sv
// ============================================================================
//  Module      : execute_stage_mc
//  Description : MIPS EX stage with operand forwarding, single-cycle ALU,
//                iterative MULTU/DIVU into HI/LO, upstream stall and
//                registered EX/MEM outputs.
//                Build option: EXEC_OVF_TRAP_EN enables ADD/SUB signed
//                overflow reporting with destination suppression.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter int ALUOP  = 4,
    parameter int REGS   = 5,
    parameter int NB_FWD = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_flush,
    input  logic [ALUOP-1:0]  i_operation,
    input  logic [NBITS-1:0]  i_reg1,
    input  logic [NBITS-1:0]  i_reg2,
    input  logic [NBITS-1:0]  i_extension,
    input  logic [REGS-1:0]   i_reg_rd,
    input  logic [REGS-1:0]   i_reg_rt,
    input  logic              i_alu_src,
    input  logic              i_select_reg,
    input  logic [NB_FWD-1:0] i_fwd_a,
    input  logic [NB_FWD-1:0] i_fwd_b,
    input  logic [NBITS-1:0]  i_exmem_data,
    input  logic [NBITS-1:0]  i_memwb_data,
    output logic              o_stall,
    output logic              o_valid,
    output logic [NBITS-1:0]  o_alu_result,
    output logic              o_cero,
    output logic [NBITS-1:0]  o_store_data,
    output logic [REGS-1:0]   o_write_reg,
    output logic              o_overflow
);

    localparam int SHW = $clog2(NBITS);

`ifdef EXEC_OVF_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [3:0]       op;
    logic [NBITS-1:0] fwd_a;
    logic [NBITS-1:0] fwd_b;
    logic [NBITS-1:0] op_b;
    logic [NBITS-1:0] sum;
    logic [NBITS-1:0] diff;
    logic [NBITS-1:0] alu_res;
    logic             ovf;
    logic             trap;
    logic             is_md;
    logic             accept;
    logic [REGS-1:0]  dest;

    logic             md_busy;
    logic             md_done;
    logic [NBITS-1:0] hi;
    logic [NBITS-1:0] lo;
    logic [NBITS-1:0] md_result;

    assign op = i_operation[3:0];

    // Forwarding muxes for rs and rt
    always_comb begin
        case (i_fwd_a)
            FWD_EXMEM: fwd_a = i_exmem_data;
            FWD_MEMWB: fwd_a = i_memwb_data;
            default:   fwd_a = i_reg1;
        endcase
        case (i_fwd_b)
            FWD_EXMEM: fwd_b = i_exmem_data;
            FWD_MEMWB: fwd_b = i_memwb_data;
            default:   fwd_b = i_reg2;
        endcase
    end

    assign op_b = i_alu_src ? i_extension : fwd_b;
    assign sum  = fwd_a + op_b;
    assign diff = fwd_a - op_b;

    // Single-cycle ALU plus signed overflow detection for ADD/SUB
    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                ovf     = (fwd_a[NBITS-1] == op_b[NBITS-1]) && (sum[NBITS-1] != fwd_a[NBITS-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                ovf     = (fwd_a[NBITS-1] != op_b[NBITS-1]) && (diff[NBITS-1] != fwd_a[NBITS-1]);
            end
            OP_AND:  alu_res = fwd_a & op_b;
            OP_OR:   alu_res = fwd_a | op_b;
            OP_XOR:  alu_res = fwd_a ^ op_b;
            OP_NOR:  alu_res = ~(fwd_a | op_b);
            OP_SLT:  alu_res = {{(NBITS-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(NBITS-1){1'b0}}, (fwd_a < op_b)};
            OP_SLL:  alu_res = op_b << fwd_a[SHW-1:0];
            OP_SRL:  alu_res = op_b >> fwd_a[SHW-1:0];
            OP_SRA:  alu_res = NBITS'($signed(op_b) >>> fwd_a[SHW-1:0]);
            OP_LUI:  alu_res = op_b << (NBITS / 2);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    assign trap   = ovf & TRAP_EN;
    assign is_md  = (op == OP_MULTU) || (op == OP_DIVU);
    assign accept = i_valid && !md_busy && !i_flush;
    assign dest   = i_select_reg ? i_reg_rd : i_reg_rt;

    muldiv_iter #(
        .NBITS (NBITS)
    ) u_muldiv (
        .clk       (i_clk),
        .rst       (i_reset),
        .flush     (i_flush),
        .start     (accept && is_md),
        .op_div    (op == OP_DIVU),
        .a         (fwd_a),
        .b         (op_b),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (hi),
        .lo        (lo),
        .result_lo (md_result)
    );

    assign o_stall = md_busy;

    // EX/MEM boundary: outputs are zero in any cycle without a valid result
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid      <= 1'b0;
            o_alu_result <= '0;
            o_cero       <= 1'b0;
            o_store_data <= '0;
            o_write_reg  <= '0;
            o_overflow   <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_alu_result <= '0;
            o_cero       <= 1'b0;
            o_store_data <= '0;
            o_write_reg  <= '0;
            o_overflow   <= 1'b0;
            if (md_done) begin
                o_valid      <= 1'b1;
                o_alu_result <= md_result;
                o_cero       <= (md_result == '0);
            end else if (accept && !is_md) begin
                o_valid      <= 1'b1;
                o_alu_result <= alu_res;
                o_cero       <= (alu_res == '0);
                o_store_data <= fwd_b;
                o_write_reg  <= trap ? '0 : dest;
                o_overflow   <= trap;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage_mc.sv
// ============================================================================
//  Module      : tb_execute_stage_mc
//  Description : Directed self-checking bench for execute_stage_mc.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage_mc;

    logic        clk;
    logic        i_reset, i_valid, i_flush;
    logic [3:0]  i_operation;
    logic [31:0] i_reg1, i_reg2, i_extension;
    logic [4:0]  i_reg_rd, i_reg_rt;
    logic        i_alu_src, i_select_reg;
    logic [1:0]  i_fwd_a, i_fwd_b;
    logic [31:0] i_exmem_data, i_memwb_data;
    logic        o_stall, o_valid, o_cero, o_overflow;
    logic [31:0] o_alu_result, o_store_data;
    logic [4:0]  o_write_reg;

    int n_cmp = 0;
    int n_bad = 0;

    execute_stage_mc dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_flush      (i_flush),
        .i_operation  (i_operation),
        .i_reg1       (i_reg1),
        .i_reg2       (i_reg2),
        .i_extension  (i_extension),
        .i_reg_rd     (i_reg_rd),
        .i_reg_rt     (i_reg_rt),
        .i_alu_src    (i_alu_src),
        .i_select_reg (i_select_reg),
        .i_fwd_a      (i_fwd_a),
        .i_fwd_b      (i_fwd_b),
        .i_exmem_data (i_exmem_data),
        .i_memwb_data (i_memwb_data),
        .o_stall      (o_stall),
        .o_valid      (o_valid),
        .o_alu_result (o_alu_result),
        .o_cero       (o_cero),
        .o_store_data (o_store_data),
        .o_write_reg  (o_write_reg),
        .o_overflow   (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        i_valid = 0; i_flush = 0; i_operation = 0;
        i_reg1 = 0; i_reg2 = 0; i_extension = 0;
        i_reg_rd = 0; i_reg_rt = 0; i_alu_src = 0; i_select_reg = 0;
        i_fwd_a = 0; i_fwd_b = 0; i_exmem_data = 0; i_memwb_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge, then drop i_valid
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        i_operation = op; i_reg1 = a; i_reg2 = b; i_valid = 1;
        step();
        i_valid = 0;
    endtask

    // Count stall-high cycles after an issue edge until stall drops (bounded)
    task automatic wait_md(output int stall_cycles, output int early_valid);
        stall_cycles = 0;
        early_valid  = 0;
        for (int i = 0; i < 40; i++) begin
            if (!o_stall) break;
            stall_cycles++;
            if (o_valid) early_valid++;
            step();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        i_reset = 1;
        repeat (2) step();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
        n_cmp++; if (o_alu_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", o_alu_result); end
        n_cmp++; if (o_write_reg !== 5'd0 || o_cero !== 1'b0) begin n_bad++; $display("FAIL reset_misc: got wr=%0d cero=%b expected 0/0", o_write_reg, o_cero); end
        i_reset = 0;
    endtask

    task automatic test_add();
        logic       exp_ovf;
        logic [4:0] exp_wr;
`ifdef EXEC_OVF_TRAP_EN
        exp_ovf = 1'b1; exp_wr = 5'd0;
`else
        exp_ovf = 1'b0; exp_wr = 5'd3;
`endif
        i_select_reg = 1; i_reg_rd = 5'd3; i_reg_rt = 5'd4;
        issue(4'd0, 32'h7FFFFFFF, 32'h1);
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b expected 1", o_valid); end
        n_cmp++; if (o_alu_result !== 32'h80000000) begin n_bad++; $display("FAIL add_result: got %h expected 80000000", o_alu_result); end
        n_cmp++; if (o_cero !== 1'b0) begin n_bad++; $display("FAIL add_cero: got %b expected 0", o_cero); end
        n_cmp++; if (o_overflow !== exp_ovf) begin n_bad++; $display("FAIL add_ovf: got %b expected %b", o_overflow, exp_ovf); end
        n_cmp++; if (o_write_reg !== exp_wr) begin n_bad++; $display("FAIL add_wreg: got %0d expected %0d", o_write_reg, exp_wr); end
        n_cmp++; if (o_store_data !== 32'h1) begin n_bad++; $display("FAIL add_store: got %h expected 1", o_store_data); end
        step();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_forwarding();
        // SUB with rs from EX/MEM
        i_fwd_a = 2'd1; i_exmem_data = 32'd5; i_select_reg = 1; i_reg_rd = 5'd7; i_reg_rt = 5'd9;
        issue(4'd1, 32'd99, 32'd5);
        n_cmp++; if (o_alu_result !== 32'h0) begin n_bad++; $display("FAIL sub_result: got %h expected 0", o_alu_result); end
        n_cmp++; if (o_cero !== 1'b1) begin n_bad++; $display("FAIL sub_cero: got %b expected 1", o_cero); end
        n_cmp++; if (o_write_reg !== 5'd7) begin n_bad++; $display("FAIL sub_wreg: got %0d expected 7", o_write_reg); end
        // OR immediate; rt forwarded from MEM/WB only feeds store data
        i_fwd_a = 2'd0; i_fwd_b = 2'd2; i_memwb_data = 32'hDEADBEEF;
        i_alu_src = 1; i_extension = 32'h0F; i_select_reg = 0;
        issue(4'd3, 32'hF0, 32'h12345678);
        n_cmp++; if (o_alu_result !== 32'hFF) begin n_bad++; $display("FAIL or_imm_result: got %h expected ff", o_alu_result); end
        n_cmp++; if (o_write_reg !== 5'd9) begin n_bad++; $display("FAIL or_imm_wreg: got %0d expected 9", o_write_reg); end
        n_cmp++; if (o_store_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL store_fwd: got %h expected deadbeef", o_store_data); end
        // LUI of immediate
        issue(4'd11, 32'h0, 32'h0);
        n_cmp++; if (o_alu_result !== 32'h000F0000) begin n_bad++; $display("FAIL lui_result: got %h expected 000f0000", o_alu_result); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        // SLT then SLTU on consecutive edges; reserved fwd_a=3 must pick ID
        i_fwd_a = 2'd3; i_exmem_data = 32'd1; i_memwb_data = 32'd1;
        @(negedge clk);
        i_operation = 4'd6; i_reg1 = 32'hFFFFFFFF; i_reg2 = 32'd1; i_valid = 1;
        step();
        n_cmp++; if (o_alu_result !== 32'd1) begin n_bad++; $display("FAIL slt_result: got %h expected 1", o_alu_result); end
        i_operation = 4'd7;
        step();
        n_cmp++; if (o_alu_result !== 32'd0 || o_valid !== 1'b1) begin n_bad++; $display("FAIL sltu_result: got %h v=%b expected 0 v=1", o_alu_result, o_valid); end
        n_cmp++; if (o_cero !== 1'b1) begin n_bad++; $display("FAIL sltu_cero: got %b expected 1", o_cero); end
        i_valid = 0;
        clear_inputs();
    endtask

    task automatic test_multu();
        int sc, ev;
        issue(4'd12, 32'hFFFFFFFF, 32'd2);
        wait_md(sc, ev);
        n_cmp++; if (sc !== 33) begin n_bad++; $display("FAIL multu_stall_cycles: got %0d expected 33", sc); end
        n_cmp++; if (ev !== 0) begin n_bad++; $display("FAIL multu_early_valid: got %0d expected 0", ev); end
        n_cmp++; if (o_valid !== 1'b1 || o_alu_result !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_done: got v=%b %h expected v=1 fffffffe", o_valid, o_alu_result); end
        n_cmp++; if (o_write_reg !== 5'd0) begin n_bad++; $display("FAIL multu_wreg: got %0d expected 0", o_write_reg); end
        issue(4'd14, 32'h0, 32'h0);
        n_cmp++; if (o_alu_result !== 32'd1) begin n_bad++; $display("FAIL multu_hi: got %h expected 1", o_alu_result); end
        issue(4'd15, 32'h0, 32'h0);
        n_cmp++; if (o_alu_result !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_lo: got %h expected fffffffe", o_alu_result); end
    endtask

    task automatic test_divu();
        int sc, ev;
        issue(4'd13, 32'd100, 32'd7);
        wait_md(sc, ev);
        n_cmp++; if (sc !== 33) begin n_bad++; $display("FAIL divu_stall_cycles: got %0d expected 33", sc); end
        n_cmp++; if (o_valid !== 1'b1 || o_alu_result !== 32'd14) begin n_bad++; $display("FAIL divu_lo: got v=%b %h expected v=1 e", o_valid, o_alu_result); end
        issue(4'd14, 32'h0, 32'h0);
        n_cmp++; if (o_alu_result !== 32'd2) begin n_bad++; $display("FAIL divu_hi: got %h expected 2", o_alu_result); end
        issue(4'd13, 32'd9, 32'd0);
        wait_md(sc, ev);
        n_cmp++; if (sc !== 33) begin n_bad++; $display("FAIL div0_stall_cycles: got %0d expected 33", sc); end
        n_cmp++; if (o_alu_result !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div0_lo: got %h expected ffffffff", o_alu_result); end
        issue(4'd14, 32'h0, 32'h0);
        n_cmp++; if (o_alu_result !== 32'd9) begin n_bad++; $display("FAIL div0_hi: got %h expected 9", o_alu_result); end
    endtask

    task automatic test_flush();
        int nv;
        issue(4'd12, 32'd3, 32'd5);
        repeat (9) step();
        @(negedge clk);
        i_flush = 1;
        step();
        i_flush = 0;
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b expected 0", o_stall); end
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid) nv++;
            step();
        end
        n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL flush_valid: got %0d valid cycles expected 0", nv); end
        issue(4'd14, 32'h0, 32'h0);
        n_cmp++; if (o_alu_result !== 32'd9) begin n_bad++; $display("FAIL flush_hi: got %h expected 9", o_alu_result); end
        issue(4'd15, 32'h0, 32'h0);
        n_cmp++; if (o_alu_result !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL flush_lo: got %h expected ffffffff", o_alu_result); end
        // Flush in the issue cycle drops the instruction
        @(negedge clk);
        i_operation = 4'd0; i_reg1 = 32'd1; i_reg2 = 32'd1; i_valid = 1; i_flush = 1;
        step();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_issue_alu: got %b expected 0", o_valid); end
        i_operation = 4'd13;
        step();
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL flush_issue_md: got %b expected 0", o_stall); end
        i_valid = 0; i_flush = 0;
    endtask

    task automatic test_sra_reset();
        issue(4'd10, 32'd4, 32'h80000000);
        n_cmp++; if (o_alu_result !== 32'hF8000000) begin n_bad++; $display("FAIL sra_result: got %h expected f8000000", o_alu_result); end
        issue(4'd13, 32'd100, 32'd7);
        repeat (5) step();
        @(negedge clk);
        i_reset = 1;
        step();
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL reset_mid_stall: got %b expected 0", o_stall); end
        n_cmp++; if (o_valid !== 1'b0 || o_alu_result !== 32'h0 || o_write_reg !== 5'd0 || o_overflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_outputs: got v=%b r=%h wr=%0d ov=%b expected zeros", o_valid, o_alu_result, o_write_reg, o_overflow);
        end
        i_reset = 0;
        issue(4'd14, 32'h0, 32'h0);
        n_cmp++; if (o_alu_result !== 32'h0 || o_cero !== 1'b1) begin n_bad++; $display("FAIL reset_hi: got %h cero=%b expected 0 cero=1", o_alu_result, o_cero); end
        issue(4'd15, 32'h0, 32'h0);
        n_cmp++; if (o_alu_result !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h expected 0", o_alu_result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forwarding();
        test_back_to_back();
        test_multu();
        test_divu();
        test_flush();
        test_sra_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
